datapath_pipe: RTL



---
 rtl/datapath_pkg.sv | 32 +++
 rtl/datapath_if.sv | 41 ++++
 rtl/alu_n.sv | 47 ++++
 rtl/datapath_pipe.sv | 139 +++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the two-stage datapath: ALU opcodes, write-back sources and the flags word.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } alu_op_e;

  // Encoding 3 is reserved and behaves like WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_DM    = 2'd1,
    WB_CONST = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/datapath_if.sv
// Issue controls, memory data and datapath results exchanged with the control FSM and memory.
interface datapath_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CONST_W = 8
) ();

  logic                  issue_valid;
  logic [2:0]            alu_op;
  logic [1:0]            wb_sel;
  logic                  sign_ext;
  logic                  negate;
  logic [CONST_W-1:0]    Val_cons;
  logic [ADDR_W-1:0]     RF_W_addr;
  logic                  RF_W_wr;
  logic [ADDR_W-1:0]     RF_Rp_addr;
  logic                  RF_Rp_rd;
  logic [ADDR_W-1:0]     RF_Rq_addr;
  logic                  RF_Rq_rd;
  logic [DATA_W-1:0]     DM_Din;
  logic [DATA_W-1:0]     Rp_data;
  logic                  RF_Rp_zero;
  logic                  wb_valid;
  logic [DATA_W-1:0]     wb_data;
  datapath_pkg::flags_t  flags;

  // Control / memory side.
  modport master (
    output issue_valid, alu_op, wb_sel, sign_ext, negate, Val_cons,
    output RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, DM_Din,
    input  Rp_data, RF_Rp_zero, wb_valid, wb_data, flags
  );

  // Datapath side.
  modport slave (
    input  issue_valid, alu_op, wb_sel, sign_ext, negate, Val_cons,
    input  RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, DM_Din,
    output Rp_data, RF_Rp_zero, wb_valid, wb_data, flags
  );

endinterface

// File: rtl/alu_n.sv
// Combinational 8-op ALU; carry meaning depends on the operation (borrow-free flag for SUB).
module alu_n
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  // Decode the operation into a result and its carry.
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    sum      = '0;
    case (op_i)
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      ALU_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i >= b_i);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_PASS: result_o = a_i;
      ALU_SHL: begin
        result_o = {a_i[DATA_W-2:0], 1'b0};
        carry_o  = a_i[DATA_W-1];
      end
      ALU_SHR: begin
        result_o = {1'b0, a_i[DATA_W-1:1]};
        carry_o  = a_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: issue/read stage with full bypass, execute/write-back stage, flags register.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RF_DEPTH = 16,
  parameter int unsigned ADDR_W   = $clog2(RF_DEPTH),
  parameter int unsigned CONST_W  = 8
) (
  input logic       clk,
  input logic       rst,
  datapath_if.slave dp
);

  logic [DATA_W-1:0]  rf_q [RF_DEPTH];

  logic               ex_valid_q;
  logic [DATA_W-1:0]  ex_a_q;
  logic [DATA_W-1:0]  ex_b_q;
  alu_op_e            ex_op_q;
  logic [1:0]         ex_wb_sel_q;
  logic               ex_sext_q;
  logic               ex_negate_q;
  logic [CONST_W-1:0] ex_const_q;
  logic [ADDR_W-1:0]  ex_dest_q;
  logic               ex_wr_q;
  flags_t             flags_q;

  logic [DATA_W-1:0]  rp_val;
  logic [DATA_W-1:0]  rq_val;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_carry;
  logic [DATA_W-1:0]  const_ext;
  logic [DATA_W-1:0]  sel_val;
  logic               sel_carry;
  logic [DATA_W-1:0]  wb_data;
  logic               ex_writes;

  // A write to R0 is discarded and so must never be forwarded either.
  assign ex_writes = ex_valid_q && ex_wr_q && (ex_dest_q != '0);

  // Operand fetch: register file, then EX bypass, then read-enable gating.
  always_comb begin
    rp_val = (dp.RF_Rp_addr == '0) ? '0 : rf_q[dp.RF_Rp_addr];
    if (ex_writes && (ex_dest_q == dp.RF_Rp_addr)) rp_val = wb_data;
    if (!dp.RF_Rp_rd) rp_val = '0;

    rq_val = (dp.RF_Rq_addr == '0) ? '0 : rf_q[dp.RF_Rq_addr];
    if (ex_writes && (ex_dest_q == dp.RF_Rq_addr)) rq_val = wb_data;
    if (!dp.RF_Rq_rd) rq_val = '0;
  end

  assign dp.Rp_data    = rp_val;
  assign dp.RF_Rp_zero = (rp_val == '0);

  alu_n #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (ex_a_q),
    .b_i      (ex_b_q),
    .op_i     (ex_op_q),
    .result_o (alu_res),
    .carry_o  (alu_carry)
  );

  // Write-back source select and optional two's-complement negate.
  always_comb begin
    const_ext = ex_sext_q ? DATA_W'($signed(ex_const_q)) : DATA_W'(ex_const_q);
    sel_val   = alu_res;
    sel_carry = alu_carry;
    case (ex_wb_sel_q)
      WB_DM: begin
        sel_val   = dp.DM_Din;
        sel_carry = 1'b0;
      end
      WB_CONST: begin
        sel_val   = const_ext;
        sel_carry = 1'b0;
      end
      default: ;
    endcase
    wb_data = '0;
    if (ex_valid_q) wb_data = ex_negate_q ? (~sel_val + DATA_W'(1'b1)) : sel_val;
  end

  assign dp.wb_valid = ex_valid_q;
  assign dp.wb_data  = wb_data;
  assign dp.flags    = flags_q;

  // Issue -> EX register; a cycle without issue_valid leaves a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_op_q     <= ALU_ADD;
      ex_wb_sel_q <= '0;
      ex_sext_q   <= 1'b0;
      ex_negate_q <= 1'b0;
      ex_const_q  <= '0;
      ex_dest_q   <= '0;
      ex_wr_q     <= 1'b0;
    end else begin
      ex_valid_q <= dp.issue_valid;
      if (dp.issue_valid) begin
        ex_a_q      <= rp_val;
        ex_b_q      <= rq_val;
        ex_op_q     <= alu_op_e'(dp.alu_op);
        ex_wb_sel_q <= dp.wb_sel;
        ex_sext_q   <= dp.sign_ext;
        ex_negate_q <= dp.negate;
        ex_const_q  <= dp.Val_cons;
        ex_dest_q   <= dp.RF_W_addr;
        ex_wr_q     <= dp.RF_W_wr;
      end
    end
  end

  // Register file write at the end of the EX cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '{default: '0};
    end else if (ex_writes) begin
      rf_q[ex_dest_q] <= wb_data;
    end
  end

  // Flags follow every valid EX op, including compares with no register write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (ex_valid_q) begin
      flags_q.z <= (wb_data == '0);
      flags_q.n <= wb_data[DATA_W-1];
      flags_q.c <= sel_carry;
    end
  end

endmodule
